// File: rtl/chroma_key_pkg.sv
// Shared definitions for the chroma-key mixer: pixel width, CSR map,
// reset values of the key/tolerance registers and the input-alignment
// FSM state type.
package chroma_key_pkg;

    localparam int PIX_W = 24;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_KEY    = 2'd1;
    localparam logic [1:0] CSR_TOL    = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam logic [PIX_W-1:0] KEY_RST = 24'h00FF00;
    localparam logic [PIX_W-1:0] TOL_RST = 24'h202020;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Signed 9-bit difference of two 8-bit channels (a - b).
    function automatic logic [8:0] chan_diff(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

endpackage

// File: rtl/chroma_key_match.sv
// Combinational key compare between pipeline stages 1 and 2.
// Ports:
//   diff_r_i/g_i/b_i : 9-bit two's-complement channel differences (pixel - key)
//   tol_i            : RGB888 per-channel tolerance
//   match_o          : 1 when every |diff| <= tolerance of that channel
module chroma_key_match
    import chroma_key_pkg::*;
(
    input  logic [8:0]       diff_r_i,
    input  logic [8:0]       diff_g_i,
    input  logic [8:0]       diff_b_i,
    input  logic [PIX_W-1:0] tol_i,
    output logic             match_o
);

    // Magnitude never exceeds 255, so 9 bits hold it without overflow.
    function automatic logic [8:0] abs9(input logic [8:0] d);
        return d[8] ? (~d + 9'd1) : d;
    endfunction

    always_comb begin
        match_o = (abs9(diff_r_i) <= {1'b0, tol_i[23:16]}) &&
                  (abs9(diff_g_i) <= {1'b0, tol_i[15:8]})  &&
                  (abs9(diff_b_i) <= {1'b0, tol_i[7:0]});
    end

endmodule

// File: rtl/chroma_key_mixer.sv
// Chroma-key compositor: joins a foreground and a background video stream
// beat by beat and replaces key-coloured foreground pixels by background.
// Ports:
//   clk, reset                       : system clock, synchronous active-high reset
//   fg_* / bg_*                      : Avalon-ST RGB888 inputs with backpressure
//   out_*                            : composited Avalon-ST output
//   csr_*                            : Avalon-MM CTRL/KEY/TOL/STATUS, 1-cycle read latency
//
// state | meaning
// SYNC  | drop non-SOP beats on each input, hold SOP until both inputs show SOP
// RUN   | accept beats only jointly; an SOP mismatch falls back to SYNC
module chroma_key_mixer
    import chroma_key_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] fg_data,
    input  logic             fg_valid,
    input  logic             fg_sop,
    input  logic             fg_eop,
    output logic             fg_ready,
    input  logic [PIX_W-1:0] bg_data,
    input  logic             bg_valid,
    input  logic             bg_sop,
    input  logic             bg_eop,
    output logic             bg_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    input  logic             out_ready,
    input  logic [1:0]       csr_address,
    input  logic             csr_write,
    input  logic [31:0]      csr_writedata,
    input  logic             csr_read,
    output logic [31:0]      csr_readdata
);

    state_e           state_q, state_d;
    logic             en_sh_q, en_act_q;
    logic [PIX_W-1:0] key_sh_q, key_act_q, tol_sh_q, tol_act_q;
    logic [15:0]      drop_q, drop_d;
    logic [31:0]      rdata_q;

    logic             v1_q, sop1_q, eop1_q;
    logic [PIX_W-1:0] fg1_q, bg1_q;
    logic [8:0]       dr1_q, dg1_q, db1_q;
    logic             v2_q, sop2_q, eop2_q;
    logic [PIX_W-1:0] pix2_q;

    logic             advance, accept, fg_drop, bg_drop, match;
    logic [PIX_W-1:0] key_eff;
    logic [1:0]       n_drop;
    logic [16:0]      drop_sum;

    logic unused_inputs;
    assign unused_inputs = ^{csr_writedata[31:24], bg_eop};

    assign advance = !v2_q || out_ready;

    always_comb begin
        accept  = 1'b0;
        fg_drop = 1'b0;
        bg_drop = 1'b0;
        state_d = state_q;
        if (!reset) begin
            case (state_q)
                ST_SYNC: begin
                    fg_drop = fg_valid && !fg_sop;
                    bg_drop = bg_valid && !bg_sop;
                    accept  = fg_valid && fg_sop && bg_valid && bg_sop && advance;
                    if (accept) state_d = ST_RUN;
                end
                default: begin
                    accept = fg_valid && bg_valid && (fg_sop == bg_sop) && advance;
                    if (fg_valid && bg_valid && (fg_sop != bg_sop)) state_d = ST_SYNC;
                end
            endcase
        end
    end

    assign fg_ready = fg_drop || accept;
    assign bg_ready = bg_drop || accept;

    // The SOP beat must already be keyed with the settings it latches.
    assign key_eff = (accept && fg_sop) ? key_sh_q : key_act_q;

    assign n_drop = {1'b0, fg_drop} + {1'b0, bg_drop};

    always_comb begin
        drop_sum = {1'b0, (csr_write && csr_address == CSR_STATUS) ? 16'd0 : drop_q}
                 + {15'd0, n_drop};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Stage 1 always holds the newest accepted beat, so the active tol/enable
    // seen while it is compared belong to that beat's frame.
    chroma_key_match u_match (
        .diff_r_i (dr1_q),
        .diff_g_i (dg1_q),
        .diff_b_i (db1_q),
        .tol_i    (tol_act_q),
        .match_o  (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SYNC;
            en_sh_q   <= 1'b0;
            en_act_q  <= 1'b0;
            key_sh_q  <= KEY_RST;
            key_act_q <= KEY_RST;
            tol_sh_q  <= TOL_RST;
            tol_act_q <= TOL_RST;
            drop_q    <= '0;
            rdata_q   <= '0;
            v1_q      <= 1'b0;
            sop1_q    <= 1'b0;
            eop1_q    <= 1'b0;
            fg1_q     <= '0;
            bg1_q     <= '0;
            dr1_q     <= '0;
            dg1_q     <= '0;
            db1_q     <= '0;
            v2_q      <= 1'b0;
            sop2_q    <= 1'b0;
            eop2_q    <= 1'b0;
            pix2_q    <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;

            if (csr_write) begin
                case (csr_address)
                    CSR_CTRL: en_sh_q  <= csr_writedata[0];
                    CSR_KEY:  key_sh_q <= csr_writedata[PIX_W-1:0];
                    CSR_TOL:  tol_sh_q <= csr_writedata[PIX_W-1:0];
                    default:  ;
                endcase
            end

            if (csr_read) begin
                case (csr_address)
                    CSR_CTRL: rdata_q <= {31'd0, en_sh_q};
                    CSR_KEY:  rdata_q <= {8'd0, key_sh_q};
                    CSR_TOL:  rdata_q <= {8'd0, tol_sh_q};
                    default:  rdata_q <= {16'd0, drop_q};
                endcase
            end

            if (accept && fg_sop) begin
                en_act_q  <= en_sh_q;
                key_act_q <= key_sh_q;
                tol_act_q <= tol_sh_q;
            end

            if (advance) begin
                v1_q <= accept;
                if (accept) begin
                    fg1_q  <= fg_data;
                    bg1_q  <= bg_data;
                    sop1_q <= fg_sop;
                    eop1_q <= fg_eop;
                    dr1_q  <= chan_diff(fg_data[23:16], key_eff[23:16]);
                    dg1_q  <= chan_diff(fg_data[15:8],  key_eff[15:8]);
                    db1_q  <= chan_diff(fg_data[7:0],   key_eff[7:0]);
                end
                v2_q <= v1_q;
                if (v1_q) begin
                    pix2_q <= (en_act_q && match) ? bg1_q : fg1_q;
                    sop2_q <= sop1_q;
                    eop2_q <= eop1_q;
                end
            end
        end
    end

    assign out_valid    = v2_q;
    assign out_data     = pix2_q;
    assign out_sop      = sop2_q;
    assign out_eop      = eop2_q;
    assign csr_readdata = rdata_q;

endmodule
